// File: rtl/rf_writeback_queue.sv
// Register-file write-side queue: round-robin arbiter between ALU and load results,
// small FIFO, registered RF write port. Optional forwarding search when WB_BYPASS_EN is defined.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_addr,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_addr,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
`ifdef WB_BYPASS_EN
  input  logic [4:0]      fwd_addr_a,
  input  logic [4:0]      fwd_addr_b,
  output logic            fwd_hit_a,
  output logic            fwd_hit_b,
  output logic [XLEN-1:0] fwd_data_a,
  output logic [XLEN-1:0] fwd_data_b,
`endif
  output logic [XLEN-1:0] rd,
  output logic [4:0]      rdAddr,
  output logic            LoadRF,
  output logic            pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]      q_addr [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            rr_last;  // 1: last contested grant went to MEM

  logic            not_full, contested, push, pop;
  logic [4:0]      push_addr;
  logic [XLEN-1:0] push_data;

  // Readiness looks only at count and rr_last, never at the same-edge pop.
  always_comb begin
    not_full  = (count != FULL);
    contested = alu_valid & mem_valid;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (not_full) begin
      if (contested) begin
        alu_ready = rr_last;
        mem_ready = ~rr_last;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
    push_addr = mem_ready ? mem_addr : alu_addr;
    push_data = mem_ready ? mem_data : alu_data;
    push      = (alu_ready | mem_ready) & (push_addr != 5'd0);
    pop       = (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rr_last <= 1'b0;
      rd      <= '0;
      rdAddr  <= '0;
      LoadRF  <= 1'b0;
    end else begin
      if (contested && not_full) rr_last <= mem_ready;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        rd     <= q_data[rd_ptr];
        rdAddr <= q_addr[rd_ptr];
        LoadRF <= 1'b1;
      end else begin
        LoadRF <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= push_addr;
      q_data[wr_ptr] <= push_data;
    end
  end

  assign pending = (count != '0) | LoadRF;

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match (youngest) wins; output register is oldest.
  function automatic logic [XLEN:0] fwd_search(input logic [4:0] a);
    logic            hit;
    logic [XLEN-1:0] d;
    logic [AW-1:0]   idx;
    hit = 1'b0;
    d   = '0;
    idx = '0;
    if (a != 5'd0) begin
      if (LoadRF && rdAddr == a) begin
        hit = 1'b1;
        d   = rd;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + AW'(i);
        if (((AW+1)'(i) < count) && (q_addr[idx] == a)) begin
          hit = 1'b1;
          d   = q_data[idx];
        end
      end
    end
    return {hit, d};
  endfunction

  logic [XLEN:0] res_a, res_b;
  always_comb begin
    res_a = fwd_search(fwd_addr_a);
    res_b = fwd_search(fwd_addr_b);
  end
  assign fwd_hit_a  = res_a[XLEN];
  assign fwd_data_a = res_a[XLEN-1:0];
  assign fwd_hit_b  = res_b[XLEN];
  assign fwd_data_b = res_b[XLEN-1:0];
`endif

endmodule
